// File: rtl/region_color_scanner_if.sv
// rtl/region_color_scanner_if.sv - framebuffer read port between scanner and framebuffer RAM
`timescale 1ns/1ps

interface region_color_scanner_if;
   logic       rd_en;
   logic [8:0] rd_x;
   logic [7:0] rd_y;
   logic [2:0] rd_color;

   // scanner side issues addresses and receives read data
   modport master (output rd_en, rd_x, rd_y, input rd_color);
   // framebuffer side answers with one cycle of read latency
   modport slave  (input rd_en, rd_x, rd_y, output rd_color);
endinterface

// File: rtl/region_color_scanner.sv
// rtl/region_color_scanner.sv - counts target-colored pixels in a square framebuffer region; REGION_FIRST_HIT_EN adds first-hit capture
`timescale 1ns/1ps

module region_color_scanner #(
   parameter int SIZE_LOG2 = 5
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   go,
   input  logic [8:0]             x_in,
   input  logic [7:0]             y_in,
   input  logic [2:0]             target_color,
   region_color_scanner_if.master fb,
   output logic                   busy,
   output logic                   done,
   output logic                   hit,
   output logic [2*SIZE_LOG2:0]   hit_count,
   output logic [8:0]             first_x,
   output logic [7:0]             first_y
);

   localparam int CW = 2 * SIZE_LOG2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [8:0]    base_x_q, base_x_d;
   logic [7:0]    base_y_q, base_y_d;
   logic [2:0]    target_q, target_d;
   logic          valid_q, valid_d;
   logic [CW:0]   hit_count_q, hit_count_d;

   logic [8:0]    rd_x_w;
   logic [7:0]    rd_y_w;
   logic          match;

   // read address is base plus the row-major offset; wraps naturally modulo 512 / 256
   assign rd_x_w = base_x_q + 9'(count_q[SIZE_LOG2-1:0]);
   assign rd_y_w = base_y_q + 8'(count_q[CW-1:SIZE_LOG2]);

   assign fb.rd_en = (state_q == SCAN);
   assign fb.rd_x  = rd_x_w;
   assign fb.rd_y  = rd_y_w;

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign hit_count = hit_count_q;
   assign hit       = |hit_count_q;

   // returned pixel belongs to the address issued one cycle earlier
   assign match = valid_q && (fb.rd_color == target_q);

`ifdef REGION_FIRST_HIT_EN
   logic       found_q, found_d;
   logic [8:0] sx_q, sx_d, first_x_q, first_x_d;
   logic [7:0] sy_q, sy_d, first_y_q, first_y_d;

   assign first_x = first_x_q;
   assign first_y = first_y_q;

   // pipeline the address alongside valid and latch the first matching coordinate
   always_comb begin
      sx_d      = rd_x_w;
      sy_d      = rd_y_w;
      found_d   = found_q;
      first_x_d = first_x_q;
      first_y_d = first_y_q;
      if (state_q == IDLE && go) begin
         found_d   = 1'b0;
         first_x_d = '0;
         first_y_d = '0;
      end else if (match && !found_q) begin
         found_d   = 1'b1;
         first_x_d = sx_q;
         first_y_d = sy_q;
      end
   end

   // first-hit registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sx_q      <= '0;
         sy_q      <= '0;
         found_q   <= 1'b0;
         first_x_q <= '0;
         first_y_q <= '0;
      end else begin
         sx_q      <= sx_d;
         sy_q      <= sy_d;
         found_q   <= found_d;
         first_x_q <= first_x_d;
         first_y_q <= first_y_d;
      end
   end
`else
   assign first_x = '0;
   assign first_y = '0;
`endif

   // next-state, offset counter, request latch and hit accumulation
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      base_x_d    = base_x_q;
      base_y_d    = base_y_q;
      target_d    = target_q;
      valid_d     = (state_q == SCAN);
      hit_count_d = hit_count_q;

      if (match) begin
         hit_count_d = hit_count_q + (CW+1)'(1);
      end

      case (state_q)
         IDLE: begin
            if (go) begin
               base_x_d    = x_in;
               base_y_d    = y_in;
               target_d    = target_color;
               hit_count_d = '0;
               count_d     = '0;
               state_d     = SCAN;
            end
         end
         SCAN: begin
            // counter wraps to zero on the last address so rd_x/rd_y fall back to the base
            count_d = count_q + CW'(1);
            if (count_q == '1) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         base_x_q    <= '0;
         base_y_q    <= '0;
         target_q    <= '0;
         valid_q     <= 1'b0;
         hit_count_q <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         base_x_q    <= base_x_d;
         base_y_q    <= base_y_d;
         target_q    <= target_d;
         valid_q     <= valid_d;
         hit_count_q <= hit_count_d;
      end
   end

endmodule

// File: doc/region_color_scanner.md
# region_color_scanner

Reads back a square pixel region of the video framebuffer and counts the pixels that match a target color. It uses the same base-coordinate-plus-offset addressing as the sprite erasers and drawers, but on the read side. Game logic uses it for collision and occupancy checks before drawing or erasing a sprite. It sits between the game controller (go/done handshake) and a read port of the framebuffer RAM, which has one cycle of read latency.

## Interface
Parameters:
- SIZE_LOG2, 5: region side is 2^SIZE_LOG2 pixels (default 32x32); offset counter is 2*SIZE_LOG2 bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  reset; asynchronous, active-low.
- go  input  1  start request; sampled only in IDLE.
- x_in  input  9  region base x; latched on accepted go.
- y_in  input  8  region base y; latched on accepted go.
- target_color  input  3  color to match; latched on accepted go.
- rd_en  output  1  framebuffer read strobe.
- rd_x  output  9  read address x.
- rd_y  output  8  read address y.
- rd_color  input  3  read data, valid the cycle after rd_en.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when results are final.
- hit  output  1  hit_count != 0; held until next accepted go.
- hit_count  output  2*SIZE_LOG2+1  number of matching pixels (0..1024 at default); held.
- first_x  output  9  x of first matching pixel in scan order (see Configuration).
- first_y  output  8  y of first matching pixel (see Configuration).

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE: on go=1, latch x_in, y_in, target_color, clear hit_count, first_x, first_y and the first-found flag, clear the offset counter; next state SCAN.
  - SCAN: rd_en=1; counter increments each cycle; leave for DRAIN after the cycle with counter = all-ones.
  - DRAIN: rd_en=0; captures the final sample.
  - DONE: done=1 for one cycle; next state IDLE.
- Address: rd_x = base_x + count[SIZE_LOG2-1:0], truncated to 9 bits. rd_y = base_y + count[2*SIZE_LOG2-1:SIZE_LOG2], truncated to 8 bits. Wrap-around is modulo 512 / 256, with no clamping.
- Scan order is row-major: x fastest, then y.
- Sample pipeline: rd_en, rd_x and rd_y are registered one stage (valid_d, sx, sy) to align with rd_color.
  - When valid_d and rd_color == latched target_color: hit_count increments.
  - On the first such match, first_x and first_y take sx and sy.
- hit_count cannot overflow; the width covers the full region.
- go is ignored in SCAN, DRAIN and DONE. Results change only on an accepted go.
- reset_n low at any time forces the following immediately, aborting any scan with no done pulse:
  - state IDLE;
  - counter, base registers and pipeline cleared;
  - all outputs 0.

## Timing
- Reset values: rd_en, busy, done, hit, hit_count, first_x, first_y, rd_x, rd_y are all 0.
- go accepted at edge 0 (go high in IDLE) gives:
  - SCAN for cycles 1..1024;
  - DRAIN in cycle 1025;
  - done high in cycle 1026;
  - IDLE in cycle 1027.
- Total latency is 2^(2*SIZE_LOG2)+2 cycles from go to done.
- rd_en is high for exactly 2^(2*SIZE_LOG2) consecutive cycles per scan.
- rd_x and rd_y are valid whenever rd_en=1. Outside SCAN they hold the base address, with offset 0.
- hit_count, hit, first_x and first_y are final and stable from the done cycle until the next accepted go.
- go held high continuously starts a new scan in the cycle after DONE (back-to-back, no gap beyond IDLE).

## Configuration
- REGION_FIRST_HIT_EN: the macro controls the first-hit coordinate capture.
  - Defined: first_x and first_y capture logic is compiled in, as described above.
  - Not defined: first_x and first_y are tied to 0, and the first-found flag and its registers are absent. hit and hit_count are unaffected.

## Test plan
- Framebuffer model all 3'b000, target 3'b000, base (10,20) -> hit_count=1024, hit=1, first=(10,20), done at cycle 1026 after go.
- Model black except pixel (13,22)=3'b100, target 3'b100, base (10,20) -> hit_count=1, first_x=13, first_y=22.
  - Repeat with REGION_FIRST_HIT_EN undefined -> first=(0,0), same count.
- Base (500,250), target none present -> rd_x sequence 500..511,0..19 and rd_y wraps 250..255,0..25; hit_count=0, hit=0.
- go re-pulsed at cycle 300 of a scan -> ignored; single done at 1026, rd_en high exactly 1024 cycles.
- reset_n dropped asynchronously mid-SCAN (cycle 500) -> all outputs 0 immediately, no done.
  - Next go completes a fresh scan with a correct count.
- go held high for 3000 cycles -> done pulses at 1026 and 2053; results of the second scan are correct.
